// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQUEST,
        SHIFT,
        ACK,
        WAIT_IDLE,
        ERROR
    } ps2_state_e;

    // Commonly sent keyboard commands and the device acknowledge byte.
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    // Falling edge on which the device drives its ACK bit.
    localparam logic [3:0] ACK_FALL_PREV = 4'd10;

    // Microseconds to system clock cycles, computed in 64 bits to avoid overflow.
    function automatic longint us_to_cycles(input longint clk_hz, input longint us);
        return (clk_hz * us) / 64'd1_000_000;
    endfunction

    // PS/2 frames carry odd parity over the data byte.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/clock_synchronizer.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module clock_synchronizer #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // Two register stages; reset to the idle (released) line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift one
// byte on device clocks, check the ACK bit, report done or error.
//
// Handshake: a command byte is taken on any cycle where command_ready and
// command_valid are both high; the source holds command_byte stable while
// command_valid is high, and command_ready stays low until the frame ends.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK          = 51_800_000,
    parameter int INHIBIT_US   = 100,
    parameter int START_TO_US  = 15_000,
    parameter int PACKET_TO_US = 2_000
) (
    input  logic       clk,
    input  logic       reset,
    output logic       command_ready,
    input  logic       command_valid,
    input  logic [7:0] command_byte,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_low,
    output logic       ps2_data_low,
    output logic       rx_inhibit,
    output logic       done,
    output logic       error,
    output ps2_state_e state_dbg
);

    localparam longint INHIBIT_CYC = us_to_cycles(longint'(CLK), longint'(INHIBIT_US));
    localparam longint START_CYC   = us_to_cycles(longint'(CLK), longint'(START_TO_US));
    localparam longint PACKET_CYC  = us_to_cycles(longint'(CLK), longint'(PACKET_TO_US));
    localparam longint MAX_AB      = (INHIBIT_CYC > START_CYC) ? INHIBIT_CYC : START_CYC;
    localparam longint MAX_CYC     = (MAX_AB > PACKET_CYC) ? MAX_AB : PACKET_CYC;
    localparam int     TW          = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYC - 1);
    localparam logic [TW-1:0] START_LAST   = TW'(START_CYC - 1);
    localparam logic [TW-1:0] PACKET_LAST  = TW'(PACKET_CYC - 1);

    ps2_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    edge_q, edge_d;
    logic [9:0]    shift_q, shift_d;     // {stop, parity, data[7:0]}, LSB goes out first
    logic          bit_low_q, bit_low_d; // data-line drive for the bit currently on the wire
    logic          ack_q, ack_d;         // data level sampled on the 11th falling edge
    logic          clk_prev_q;
    logic          clk_sync;
    logic          data_sync;
    logic          fall;

    clock_synchronizer #(.RESET_VAL(1'b1)) u_sync_clk (
        .clk     (clk),
        .reset   (reset),
        .async_i (ps2_clk_in),
        .sync_o  (clk_sync)
    );

    clock_synchronizer #(.RESET_VAL(1'b1)) u_sync_data (
        .clk     (clk),
        .reset   (reset),
        .async_i (ps2_data_in),
        .sync_o  (data_sync)
    );

    assign fall          = clk_prev_q & ~clk_sync;
    assign command_ready = (state_q == IDLE);
    assign rx_inhibit    = (state_q != IDLE);
    assign state_dbg     = state_q;

    // State, counters and shift register; reset releases both lines at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            edge_q     <= '0;
            shift_q    <= '0;
            bit_low_q  <= 1'b0;
            ack_q      <= 1'b0;
            clk_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            edge_q     <= edge_d;
            shift_q    <= shift_d;
            bit_low_q  <= bit_low_d;
            ack_q      <= ack_d;
            clk_prev_q <= clk_sync;
        end
    end

    // Next-state, line drive and done/error pulses.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        edge_d       = edge_q;
        shift_d      = shift_q;
        bit_low_d    = bit_low_q;
        ack_d        = ack_q;
        ps2_clk_low  = 1'b0;
        ps2_data_low = 1'b0;
        done         = 1'b0;
        error        = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (command_valid) begin
                    shift_d   = {1'b1, odd_parity(command_byte), command_byte};
                    edge_d    = '0;
                    bit_low_d = 1'b0;
                    state_d   = INHIBIT;
                end
            end

            INHIBIT: begin
                ps2_clk_low = 1'b1;
                timer_d     = timer_q + TW'(1);
                if (timer_q == INHIBIT_LAST) begin
                    // Start bit goes low while the clock is still held.
                    ps2_data_low = 1'b1;
                    timer_d      = '0;
                    state_d      = REQUEST;
                end
            end

            REQUEST: begin
                ps2_data_low = 1'b1;
                timer_d      = timer_q + TW'(1);
                if (fall) begin
                    edge_d    = edge_q + 4'd1;
                    bit_low_d = ~shift_q[0];
                    shift_d   = {1'b1, shift_q[9:1]};
                    timer_d   = '0;     // packet timeout runs from the first fall
                    state_d   = SHIFT;
                end else if (timer_q == START_LAST) begin
                    state_d = ERROR;
                end
            end

            SHIFT: begin
                ps2_data_low = bit_low_q;
                timer_d      = timer_q + TW'(1);
                if (timer_q == PACKET_LAST) begin
                    state_d = ERROR;
                end else if (fall) begin
                    edge_d = edge_q + 4'd1;
                    if (edge_q == ACK_FALL_PREV) begin
                        ack_d   = data_sync;
                        state_d = ACK;
                    end else begin
                        bit_low_d = ~shift_q[0];
                        shift_d   = {1'b1, shift_q[9:1]};
                    end
                end
            end

            ACK: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == PACKET_LAST || ack_q) begin
                    state_d = ERROR;
                end else begin
                    state_d = WAIT_IDLE;
                end
            end

            WAIT_IDLE: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == PACKET_LAST) begin
                    state_d = ERROR;
                end else if (clk_sync && data_sync) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end

            ERROR: begin
                error   = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with a behavioural PS/2 device clocking at 10 kHz
// against a 1 MHz system clock (100 system cycles per PS/2 bit).
module tb_ps2_host_tx;
    import ps2_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic       command_ready;
    logic       command_valid;
    logic [7:0] command_byte;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_low;
    logic       ps2_data_low;
    logic       rx_inhibit;
    logic       done;
    logic       error;
    ps2_state_e state_dbg;

    logic       dev_clk;
    logic       dev_data;

    always #5 clk = ~clk;

    // Open-drain wired-AND of host and device on each line.
    assign ps2_clk_in  = dev_clk  & ~ps2_clk_low;
    assign ps2_data_in = dev_data & ~ps2_data_low;

    ps2_host_tx #(
        .CLK          (1_000_000),
        .INHIBIT_US   (100),
        .START_TO_US  (15_000),
        .PACKET_TO_US (2_000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .command_ready (command_ready),
        .command_valid (command_valid),
        .command_byte  (command_byte),
        .ps2_clk_in    (ps2_clk_in),
        .ps2_data_in   (ps2_data_in),
        .ps2_clk_low   (ps2_clk_low),
        .ps2_data_low  (ps2_data_low),
        .rx_inhibit    (rx_inhibit),
        .done          (done),
        .error         (error),
        .state_dbg     (state_dbg)
    );

    // ---------------- bookkeeping ----------------
    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_range(input string name, input longint got, input longint lo, input longint hi);
        tests++;
        if (got < lo || got > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    // ---------------- monitor ----------------
    int   done_cnt, err_cnt, both_cnt, clk_low_cyc, accepts, inhib_bad;
    int   rel_cyc, err_cyc;
    logic clk_low_prev = 1'b0;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (done && error) both_cnt++;
        if (ps2_clk_low) clk_low_cyc++;
        if (clk_low_prev && !ps2_clk_low && rel_cyc < 0) rel_cyc = cyc;
        if (error && err_cyc < 0) err_cyc = cyc;
        if (command_ready && command_valid) accepts++;
        if (done && !rx_inhibit) inhib_bad++;
        clk_low_prev = ps2_clk_low;
    end

    // ---------------- device model ----------------
    int          dev_falls;
    int          fall1_cyc;
    logic [10:0] dev_frame;   // {stop, parity, data[7:0], start} as sampled by the device
    bit          abort_dev;

    task automatic dev_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic device_run(input int nfalls, input bit ack);
        int w;
        dev_falls = 0;
        dev_frame = '0;
        w = 0;
        while (!ps2_clk_low && w < 2000) begin @(posedge clk); #1; w++; end
        while (ps2_clk_low && w < 2000) begin @(posedge clk); #1; w++; end
        check("dev_request_seen", (w < 2000) && ps2_data_low, 1);
        if (nfalls == 0) return;
        dev_wait(20);
        dev_frame[0] = ps2_data_in;
        for (int i = 1; i <= nfalls && i <= 11; i++) begin
            if (i == 11) begin
                dev_data = ~ack;
                dev_wait(10);
            end
            dev_clk = 1'b0;
            if (i == 1) fall1_cyc = cyc;
            dev_falls = i;
            dev_wait(50);
            if (abort_dev) begin dev_clk = 1'b1; dev_data = 1'b1; return; end
            dev_clk = 1'b1;
            if (i <= 10) dev_frame[i] = ps2_data_in;
            dev_wait(50);
            if (abort_dev) begin dev_data = 1'b1; return; end
        end
        dev_data = 1'b1;
    endtask

    // ---------------- driver ----------------
    task automatic reset_counters();
        done_cnt = 0; err_cnt = 0; both_cnt = 0; clk_low_cyc = 0;
        accepts = 0; inhib_bad = 0; rel_cyc = -1; err_cyc = -1; fall1_cyc = -1;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        int n;
        @(posedge clk); #1;
        command_byte  = b;
        command_valid = 1'b1;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (command_ready) break;
            n++;
        end
        @(posedge clk); #1;
        command_valid = 1'b0;
    endtask

    task automatic wait_outcome(input int bound);
        int n;
        n = 0;
        while (n < bound) begin
            @(negedge clk);
            n++;
            if (done || error) break;
        end
        check("outcome_within_bound", n < bound, 1);
        repeat (5) @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic [7:0]  cmd;
        int          nfalls;
        bit          ack;
        logic [10:0] frame;
        int          exp_done;
        int          exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int w;

        // Frames are {stop=1, odd parity, byte, start=0}.
        vecs[0] = '{"set_leds",   8'hED, 11, 1'b1, {1'b1, 1'b1, 8'hED, 1'b0}, 1, 0}; // six 1s -> parity 1
        vecs[1] = '{"enable",     8'hF4, 11, 1'b1, {1'b1, 1'b0, 8'hF4, 1'b0}, 1, 0}; // five 1s -> parity 0
        vecs[2] = '{"zero",       8'h00, 11, 1'b1, {1'b1, 1'b1, 8'h00, 1'b0}, 1, 0}; // no 1s -> parity 1
        vecs[3] = '{"no_ack",     8'hEE, 11, 1'b0, {1'b1, 1'b1, 8'hEE, 1'b0}, 0, 1}; // six 1s -> parity 1
        vecs[4] = '{"stall_5",    8'hED,  5, 1'b1, 11'h0,                     0, 1};
        vecs[5] = '{"no_device",  8'hFF,  0, 1'b1, 11'h0,                     0, 1};

        reset         = 1'b1;
        command_valid = 1'b0;
        command_byte  = 8'h00;
        dev_clk       = 1'b1;
        dev_data      = 1'b1;
        abort_dev     = 1'b0;
        reset_counters();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_ready",      command_ready, 1);
        check("reset_clk_low",    ps2_clk_low,   0);
        check("reset_data_low",   ps2_data_low,  0);
        check("reset_done",       done,          0);
        check("reset_error",      error,         0);
        check("reset_rx_inhibit", rx_inhibit,    0);

        foreach (vecs[k]) begin
            reset_counters();
            fork
                device_run(vecs[k].nfalls, vecs[k].ack);
                begin
                    send_cmd(vecs[k].cmd);
                    wait_outcome(20_000);
                end
            join
            repeat (3) @(negedge clk);
            if (vecs[k].nfalls == 11)
                check({vecs[k].name, "_frame"}, dev_frame, vecs[k].frame);
            check({vecs[k].name, "_done_pulses"},  done_cnt,      vecs[k].exp_done);
            check({vecs[k].name, "_error_pulses"}, err_cnt,       vecs[k].exp_err);
            check({vecs[k].name, "_both"},         both_cnt,      0);
            check({vecs[k].name, "_inhibit_len"},  clk_low_cyc,   100);
            check({vecs[k].name, "_accepts"},      accepts,       1);
            check({vecs[k].name, "_rx_inhibit"},   inhib_bad,     0);
            check({vecs[k].name, "_ready_after"},  command_ready, 1);
            check({vecs[k].name, "_clk_rel"},      ps2_clk_low,   0);
            check({vecs[k].name, "_data_rel"},     ps2_data_low,  0);
            if (vecs[k].nfalls == 0)
                check("start_timeout_cycles", err_cyc - rel_cyc, 15_000);
            if (vecs[k].nfalls == 5)
                check_range("packet_timeout_cycles", err_cyc - fall1_cyc, 2000, 2005);
        end

        // Reset during data bit 4 of 0x00: data line is driven low, then released at once.
        reset_counters();
        abort_dev = 1'b0;
        fork
            device_run(11, 1'b1);
            begin
                send_cmd(8'h00);
                w = 0;
                while (dev_falls < 4 && w < 3000) begin @(posedge clk); w++; end
                check("reached_bit4", dev_falls >= 4, 1);
                repeat (10) @(posedge clk);
                #1;
                check("data_low_before_reset", ps2_data_low, 1);
                reset     = 1'b1;
                abort_dev = 1'b1;
                #1;
                check("reset_mid_clk_low",  ps2_clk_low,  0);
                check("reset_mid_data_low", ps2_data_low, 0);
            end
        join
        repeat (3) @(posedge clk);
        #1;
        reset     = 1'b0;
        abort_dev = 1'b0;
        dev_clk   = 1'b1;
        dev_data  = 1'b1;
        @(negedge clk);
        check("ready_after_mid_reset", command_ready, 1);

        reset_counters();
        fork
            device_run(11, 1'b1);
            begin
                send_cmd(CMD_RESET);
                wait_outcome(20_000);
            end
        join
        check("reset_cmd_frame", dev_frame, {1'b1, 1'b1, 8'hFF, 1'b0}); // eight 1s -> parity 1
        check("reset_cmd_done",  done_cnt,  1);
        check("reset_cmd_error", err_cnt,   0);

        // command_valid held through a whole transfer: only one byte taken.
        reset_counters();
        fork
            device_run(11, 1'b1);
            begin
                @(posedge clk); #1;
                command_byte  = 8'hF4;
                command_valid = 1'b1;
                w = 0;
                while (w < 20_000) begin
                    @(negedge clk);
                    w++;
                    if (done || error) break;
                end
                command_valid = 1'b0;
                check("held_outcome_within_bound", w < 20_000, 1);
            end
        join
        repeat (5) @(negedge clk);
        check("held_accepts",    accepts,   1);
        check("held_done",       done_cnt,  1);
        check("held_error",      err_cnt,   0);
        check("held_frame",      dev_frame, {1'b1, 1'b0, 8'hF4, 1'b0});
        check("held_rx_inhibit", inhib_bad, 0);
        check("held_ready",      command_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
